mem_port_arb: RTL and testbench

Shared-memory port arbiter and RAM for the array's RAM-backed top level. It merges NR read-channel ports and one strobed write port onto a single-port internal memory of DEPTH words. A round-robin arbiter grants at most one access per cycle, and read data returns after a parametrised fixed latency. It generalises the fixed one-cycle, always-served mm2s/s2mm port pattern with per-channel grant backpressure, configurable depth, latency and channel count.

---
 rtl/mem_port_arb_if.sv | 28 ++
 rtl/mem_port_arb.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arb.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_if.sv
// Request/grant/data bundle between the memory requestors and mem_port_arb.
// master: requestor side (read channels + write port); slave: the arbiter.
interface mem_port_arb_if #(
  parameter int NR        = 3,
  parameter int AXI_WIDTH = 128,
  parameter int ADDR_W    = 28
);
  logic [NR-1:0]           rd_req;
  logic [NR*ADDR_W-1:0]    rd_addr;
  logic [NR-1:0]           rd_gnt;
  logic [NR-1:0]           rd_valid;
  logic [NR*AXI_WIDTH-1:0] rd_data;
  logic                    wr_req;
  logic [ADDR_W-1:0]       wr_addr;
  logic [AXI_WIDTH-1:0]    wr_data;
  logic [AXI_WIDTH/8-1:0]  wr_strb;
  logic                    wr_gnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_strb,
    input  rd_gnt, rd_valid, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_strb,
    output rd_gnt, rd_valid, rd_data, wr_gnt
  );
endinterface

// File: rtl/mem_port_arb.sv
// Round-robin arbiter merging NR read channels and one strobed write port onto a single-port RAM.
// Define MEM_PORT_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module mem_port_arb #(
  parameter int NR        = 3,
  parameter int AXI_WIDTH = 128,
  parameter int ADDR_W    = 28,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          rstn,
`ifdef MEM_PORT_ARB_STALL_CNT_EN
  output logic [31:0]   stall_cnt,
`endif
  mem_port_arb_if.slave bus
);
  localparam int NREQ = NR + 1;
  localparam int PW   = $clog2(NREQ);
  localparam int CW   = (NR > 1) ? $clog2(NR) : 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB   = AXI_WIDTH / 8;

  logic [NREQ-1:0] req_all;
  logic [NREQ-1:0] gnt_all;
  logic [PW-1:0]   p_q, p_d;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;

  assign req_all = {bus.wr_req, bus.rd_req};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    gnt_all = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Upper half of the ring (p .. NR) has priority over the wrapped part (0 .. p-1).
    for (int k = 0; k < NREQ; k++) begin
      if (rstn && !gnt_any && req_all[k] && (PW'(k) >= p_q)) begin
        gnt_any    = 1'b1;
        gnt_idx    = PW'(k);
        gnt_all[k] = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (rstn && !gnt_any && req_all[k] && (PW'(k) < p_q)) begin
        gnt_any    = 1'b1;
        gnt_idx    = PW'(k);
        gnt_all[k] = 1'b1;
      end
    end
  end

  always_comb begin
    p_d = p_q;
    if (gnt_any) p_d = (gnt_idx == PW'(NR)) ? '0 : gnt_idx + 1'b1;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) p_q <= '0;
    else       p_q <= p_d;
  end

  assign bus.rd_gnt = gnt_all[NR-1:0];
  assign bus.wr_gnt = gnt_all[NR];

  logic          rd_fire;
  logic [CW-1:0] rd_ch;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          unused_addr;

  always_comb begin
    rd_ch  = '0;
    rd_idx = '0;
    for (int i = 0; i < NR; i++) begin
      if (gnt_all[i]) begin
        rd_ch  = CW'(i);
        rd_idx = bus.rd_addr[i*ADDR_W +: AW];
      end
    end
  end

  assign rd_fire     = |gnt_all[NR-1:0];
  assign wr_idx      = bus.wr_addr[AW-1:0];
  assign unused_addr = ^{bus.rd_addr, bus.wr_addr};

  logic [AXI_WIDTH-1:0] mem_q [DEPTH];
  logic [AXI_WIDTH-1:0] rd_word;

  // NOTE: the RAM array carries no reset so it maps onto block RAM; only control state resets.
  always_ff @(posedge clk) begin
    if (gnt_all[NR]) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_strb[b]) mem_q[wr_idx][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_word = mem_q[rd_idx];

  // Exit point of the read pipeline: valid/channel/data that land in the output registers.
  logic                 x_vld;
  logic [CW-1:0]        x_ch;
  logic [AXI_WIDTH-1:0] x_data;

  if (RD_LAT == 1) begin : g_lat1
    assign x_vld  = rd_fire;
    assign x_ch   = rd_ch;
    assign x_data = rd_word;
  end else begin : g_pipe
    logic [RD_LAT-2:0]    vld_q;
    logic [CW-1:0]        ch_q  [RD_LAT-1];
    logic [AXI_WIDTH-1:0] dat_q [RD_LAT-1];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rd_fire;
        for (int s = 1; s < RD_LAT-1; s++) vld_q[s] <= vld_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      ch_q[0]  <= rd_ch;
      dat_q[0] <= rd_word;
      for (int s = 1; s < RD_LAT-1; s++) begin
        ch_q[s]  <= ch_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
    end

    assign x_vld  = vld_q[RD_LAT-2];
    assign x_ch   = ch_q[RD_LAT-2];
    assign x_data = dat_q[RD_LAT-2];
  end

  logic [NR-1:0]           rd_valid_q;
  logic [NR*AXI_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= '0;
      for (int i = 0; i < NR; i++) begin
        if (x_vld && (x_ch == CW'(i))) begin
          rd_valid_q[i]                        <= 1'b1;
          rd_data_q[i*AXI_WIDTH +: AXI_WIDTH]  <= x_data;
        end
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

`ifdef MEM_PORT_ARB_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall;

  assign stall = |(req_all & ~gnt_all);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           stall_q <= '0;
    else if (stall && (stall_q != '1))   stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus random traffic against a
// transaction-level model (round-robin search, byte-strobed array, fixed-latency read queue).
module tb_mem_port_arb;
  localparam int NR        = 3;
  localparam int AXI_WIDTH = 128;
  localparam int ADDR_W    = 28;
  localparam int DEPTH     = 16;
  localparam int RD_LAT    = 3;
  localparam int NB        = AXI_WIDTH / 8;
  localparam int CHK_W     = NR * AXI_WIDTH;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_port_arb_if #(.NR(NR), .AXI_WIDTH(AXI_WIDTH), .ADDR_W(ADDR_W)) bus ();
`ifdef MEM_PORT_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  mem_port_arb #(
    .NR(NR), .AXI_WIDTH(AXI_WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
`ifdef MEM_PORT_ARB_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus  (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Requestor state: index NR is the write port. Held until granted.
  bit                   want     [NR+1];
  logic [ADDR_W-1:0]    req_addr [NR+1];
  logic [AXI_WIDTH-1:0] w_data;
  logic [NB-1:0]        w_strb;

  // Reference model.
  typedef struct {
    int                   due;
    int                   ch;
    logic [AXI_WIDTH-1:0] data;
  } rd_t;

  logic [AXI_WIDTH-1:0] m_mem     [DEPTH];
  logic [AXI_WIDTH-1:0] m_rd_data [NR];
  int                   m_p;
  rd_t                  m_pipe [$];
  logic [31:0]          m_stall;
  int                   gnt_log [$];

  task automatic check(input string tag, input logic [CHK_W-1:0] obs, input logic [CHK_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit any_want();
    bit r = 1'b0;
    for (int k = 0; k <= NR; k++) r |= want[k];
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.rd_req[i]                     = want[i];
      bus.rd_addr[i*ADDR_W +: ADDR_W]   = req_addr[i];
    end
    bus.wr_req  = want[NR];
    bus.wr_addr = req_addr[NR];
    bus.wr_data = w_data;
    bus.wr_strb = w_strb;
  endtask

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < NR; i++) m_rd_data[i] = '0;
    m_p     = 0;
    m_stall = '0;
  endtask

  // One clock cycle: drive, compare at the falling edge, commit the model, advance.
  task automatic tick();
    logic [NR:0]      exp_gnt, obs_gnt;
    logic [NR-1:0]    exp_vld;
    logic [CHK_W-1:0] exp_data;
    int               g, idx, seen;
    bit               stalled;
    rd_t              e;
    drive();
    @(negedge clk);
    g = -1;
    if (rstn) begin
      for (int k = 0; k <= NR; k++) begin
        idx = (m_p + k) % (NR + 1);
        if (g < 0 && want[idx]) g = idx;
      end
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    obs_gnt = {bus.wr_gnt, bus.rd_gnt};
    check("grant", obs_gnt, exp_gnt);
    seen = -1;
    for (int k = 0; k <= NR; k++) if (obs_gnt[k] === 1'b1) seen = k;
    gnt_log.push_back(seen);

    exp_vld = '0;
    while (m_pipe.size() > 0 && m_pipe[0].due == cyc) begin
      e = m_pipe.pop_front();
      exp_vld[e.ch]   = 1'b1;
      m_rd_data[e.ch] = e.data;
    end
    check("rd_valid", bus.rd_valid, exp_vld);
    for (int i = 0; i < NR; i++) exp_data[i*AXI_WIDTH +: AXI_WIDTH] = m_rd_data[i];
    check("rd_data", bus.rd_data, exp_data);

`ifdef MEM_PORT_ARB_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
    stalled = 1'b0;
    for (int k = 0; k <= NR; k++) if (want[k] && k != g) stalled = 1'b1;
    if (rstn && stalled && m_stall != 32'hFFFF_FFFF) m_stall++;
`else
    stalled = 1'b0;
`endif

    if (g == NR) begin
      for (int b = 0; b < NB; b++)
        if (w_strb[b]) m_mem[req_addr[NR] % DEPTH][b*8 +: 8] = w_data[b*8 +: 8];
    end else if (g >= 0) begin
      m_pipe.push_back('{due: cyc + RD_LAT, ch: g, data: m_mem[req_addr[g] % DEPTH]});
    end
    if (g >= 0) begin
      m_p     = (g + 1) % (NR + 1);
      want[g] = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic reset_pulse(input int n);
    rstn = 1'b0;
    model_reset();
    repeat (n) tick();
    rstn = 1'b1;
  endtask

  task automatic wr_set(input int a, input logic [AXI_WIDTH-1:0] d, input logic [NB-1:0] s);
    want[NR]     = 1'b1;
    req_addr[NR] = ADDR_W'(a);
    w_data       = d;
    w_strb       = s;
  endtask

  task automatic rd_set(input int ch, input int a);
    want[ch]     = 1'b1;
    req_addr[ch] = ADDR_W'(a);
  endtask

  task automatic run_until_idle(input int budget);
    int b = budget;
    while (any_want() && b > 0) begin
      tick();
      b--;
    end
    check("grant_timeout", any_want(), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int cnt [NR+1];
    for (int k = 0; k <= NR; k++) begin
      want[k]     = 1'b0;
      req_addr[k] = '0;
    end
    w_data = '0;
    w_strb = '0;
    drive();

    // Reset values.
    reset_pulse(2);
    check("reset_rd_data", bus.rd_data, '0);
    check("reset_rd_valid", bus.rd_valid, '0);

    // Preload every word so later reads compare defined data.
    for (int a = 0; a < DEPTH; a++) begin
      wr_set(a, {$urandom, $urandom, $urandom, $urandom}, '1);
      run_until_idle(4);
    end

    // Single write then read on channel 1.
    wr_set(5, {16{8'hA5}}, '1);
    run_until_idle(4);
    rd_set(1, 5);
    run_until_idle(4);
    repeat (RD_LAT) tick();
    check("a5_readback", bus.rd_data[1*AXI_WIDTH +: AXI_WIDTH], {16{8'hA5}});

    // Partial strobe: only bytes 0-1 change.
    wr_set(7, {16{8'h11}}, '1);
    run_until_idle(4);
    wr_set(7, {16{8'hFF}}, 16'h0003);
    run_until_idle(4);
    rd_set(2, 7);
    run_until_idle(4);
    repeat (RD_LAT) tick();
    check("partial_strobe", bus.rd_data[2*AXI_WIDTH +: AXI_WIDTH], {{14{8'h11}}, 16'hFFFF});

    // Address wrap: 18 aliases 2 when DEPTH is 16.
    wr_set(2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '1);
    run_until_idle(4);
    rd_set(0, 18);
    run_until_idle(4);
    repeat (RD_LAT) tick();
    check("wrap_readback", bus.rd_data[0 +: AXI_WIDTH], 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

    // Idle pointer hold: after ch2 the pointer rests on W, so ch0 wins next.
    rd_set(2, 3);
    run_until_idle(4);
    repeat (5) tick();
    rd_set(0, 1);
    rd_set(1, 4);
    gnt_log.delete();
    run_until_idle(4);
    check("idle_first", gnt_log[0], 0);
    check("idle_second", gnt_log[1], 1);
    repeat (RD_LAT + 1) tick();

    // Fairness from reset with everyone requesting continuously.
    for (int k = 0; k < NR; k++) rd_set(k, k + 10);
    wr_set(9, {8{16'hBEEF}}, '1);
    reset_pulse(2);
    gnt_log.delete();
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k <= NR; k++) want[k] = 1'b1;
      tick();
    end
    for (int k = 0; k <= NR; k++) begin
      want[k] = 1'b0;
      cnt[k]  = 0;
    end
    for (int n = 0; n < 12; n++) begin
      check("rr_order", gnt_log[n], n % (NR + 1));
      if (gnt_log[n] >= 0) cnt[gnt_log[n]]++;
    end
    for (int k = 0; k <= NR; k++) check("rr_share", cnt[k], 3);
    repeat (RD_LAT + 1) tick();

    // Reset with reads in flight; held requests see no grant during reset.
    rd_set(0, 5);
    rd_set(2, 7);
    tick();
    tick();
    rd_set(1, 2);
    wr_set(9, {16{8'h5A}}, '1);
    reset_pulse(3);
    gnt_log.delete();
    run_until_idle(8);
    check("post_reset_first", gnt_log[0], 1);
    repeat (RD_LAT + 2) tick();
    rd_set(0, 5);
    run_until_idle(4);
    repeat (RD_LAT) tick();
    check("mem_survives_reset", bus.rd_data[0 +: AXI_WIDTH], {16{8'hA5}});

    // Random traffic: new requests only when the previous one was granted.
    for (int n = 0; n < 600; n++) begin
      for (int r = 0; r <= NR; r++) begin
        if (!want[r] && $urandom_range(1, 0) == 1) begin
          want[r]     = 1'b1;
          req_addr[r] = ADDR_W'($urandom);
          if (r == NR) begin
            w_data = {$urandom, $urandom, $urandom, $urandom};
            w_strb = NB'($urandom);
          end
        end
      end
      tick();
    end
    run_until_idle(16);
    repeat (RD_LAT + 1) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
